// File: rtl/board_render_seq_if.sv
// board_render_seq_if
//   Groups the sequencer's signals into one bundle. These cover the game-logic
//   control (start/busy/done), the board RAM port (map_addr/map_data) and the
//   drawer handshake (x_out/y_out/sprite_id_out/begin_draw).
//
//   master : the sequencer (board_render_seq)
//   slave  : the surrounding system (game logic, board RAM, sprite_draw)
//
//   start          request a full-board render (sampled only while idle)
//   busy           high whenever the sequencer is not idle
//   done           one-cycle pulse after the last tile's wait
//   map_addr[8:0]  board RAM read address, row*COLS+col
//   map_data[3:0]  board RAM read data, valid one cycle after map_addr
//   x_out[7:0]     tile anchor x (col*8)
//   y_out[6:0]     tile anchor y (row*8)
//   sprite_id_out  sprite id of the current tile
//   begin_draw     go strobe to sprite_draw
interface board_render_seq_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [8:0] map_addr;
    logic [3:0] map_data;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [3:0] sprite_id_out;
    logic       begin_draw;

    modport master (
        input  start,
        input  map_data,
        output busy,
        output done,
        output map_addr,
        output x_out,
        output y_out,
        output sprite_id_out,
        output begin_draw
    );

    modport slave (
        output start,
        output map_data,
        input  busy,
        input  done,
        input  map_addr,
        input  x_out,
        input  y_out,
        input  sprite_id_out,
        input  begin_draw
    );
endinterface

// File: rtl/board_render_seq.sv
// board_render_seq
//   Repaints the whole screen as a grid of 8x8 tiles. The sequencer walks the
//   tile map held in an external synchronous-read board RAM, one tile at a time.
//   For each tile it presents the pixel anchor and sprite id to sprite_draw,
//   holds begin_draw for GO_CYCLES cycles, and then idles WAIT_CYCLES cycles so
//   the drawer can finish its 64-pixel plot and return to its load state.
//
// Parameters
//   COLS, ROWS   grid size in tiles (COLS*ROWS <= 512)
//   GO_CYCLES    begin_draw high time per tile (>= 1)
//   WAIT_CYCLES  quiet time after begin_draw falls (>= 66)
//
// Ports
//   clk     clock
//   resetn  synchronous, active-low reset
//   bus     board_render_seq_if master modport (control, RAM port, drawer port)
module board_render_seq #(
    parameter int COLS        = 20,
    parameter int ROWS        = 15,
    parameter int GO_CYCLES   = 2,
    parameter int WAIT_CYCLES = 68
) (
    input  logic                  clk,
    input  logic                  resetn,
    board_render_seq_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_GO,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    localparam int               CNT_W     = 16;
    // The down-counter is loaded with N-1 so that a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] GO_LOAD   = CNT_W'(GO_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [4:0]       COL_LAST  = 5'(COLS - 1);
    localparam logic [3:0]       ROW_LAST  = 4'(ROWS - 1);

    state_t           state;
    logic [4:0]       col;
    logic [3:0]       row;
    logic [CNT_W-1:0] cnt;

    logic last_col;
    logic last_row;

    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

    // All outputs are registered and change only on a state transition.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register in this block samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the reset is synchronous; every register, including the
            // grid position and counter, is cleared so no partial tile resumes.
            state             <= S_IDLE;
            col               <= '0;
            row               <= '0;
            cnt               <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.begin_draw    <= 1'b0;
            bus.map_addr      <= '0;
            bus.x_out         <= '0;
            bus.y_out         <= '0;
            bus.sprite_id_out <= '0;
        end else begin
            // done is a single-cycle pulse; only the ADVANCE->DONE edge raises it.
            bus.done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        col          <= '0;
                        row          <= '0;
                        bus.map_addr <= '0;
                        bus.busy     <= 1'b1;
                        state        <= S_FETCH;
                    end
                end

                // map_addr has been stable since the previous edge; the RAM
                // read is in flight and its data is valid in LATCH.
                S_FETCH: begin
                    state <= S_LATCH;
                end

                S_LATCH: begin
                    bus.sprite_id_out <= bus.map_data;
                    bus.x_out         <= {col, 3'b000};
                    bus.y_out         <= {row, 3'b000};
                    bus.begin_draw    <= 1'b1;
                    cnt               <= GO_LOAD;
                    state             <= S_GO;
                end

                S_GO: begin
                    if (cnt == '0) begin
                        bus.begin_draw <= 1'b0;
                        cnt            <= WAIT_LOAD;
                        state          <= S_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // Anchor and id stay untouched here, which covers the drawer's
                // load cycle right after begin_draw falls.
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_ADVANCE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_ADVANCE: begin
                    if (last_col && last_row) begin
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        if (last_col) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        // Raster order means the address is simply the next one.
                        bus.map_addr <= bus.map_addr + 9'd1;
                        state        <= S_FETCH;
                    end
                end

                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    bus.busy       <= 1'b0;
                    bus.begin_draw <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_render_seq.sv
// tb_board_render_seq
//   Directed bench for board_render_seq. Instance A uses the default 20x15
//   grid and instance B a 2x2 grid. Each instance is backed by a synchronous
//   RAM model that returns map[a] = a mod 16. Cycle labels follow the
//   convention that the edge sampling start is cycle 0. The first sample
//   after that edge, taken at the falling edge, is therefore cycle 1 (FETCH of
//   tile 0).
module tb_board_render_seq;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    board_render_seq_if bus_a ();
    board_render_seq_if bus_b ();

    board_render_seq #(
        .COLS(20), .ROWS(15), .GO_CYCLES(2), .WAIT_CYCLES(68)
    ) dut_a (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus_a.master)
    );

    board_render_seq #(
        .COLS(2), .ROWS(2), .GO_CYCLES(2), .WAIT_CYCLES(68)
    ) dut_b (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus_b.master)
    );

    // Synchronous-read board RAM models: data valid the cycle after the address.
    always_ff @(posedge clk) begin
        bus_a.map_data <= bus_a.map_addr[3:0];
        bus_b.map_data <= bus_b.map_addr[3:0];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_busy"}, int'(bus_a.busy), 0);
        check({tag, "_done"}, int'(bus_a.done), 0);
        check({tag, "_go"},   int'(bus_a.begin_draw), 0);
        check({tag, "_addr"}, int'(bus_a.map_addr), 0);
        check({tag, "_x"},    int'(bus_a.x_out), 0);
        check({tag, "_y"},    int'(bus_a.y_out), 0);
        check({tag, "_id"},   int'(bus_a.sprite_id_out), 0);
    endtask

    // Hand-computed tile expectations for the default grid.
    int tile_k [3] = '{0, 21, 299};
    int tile_x [3] = '{0, 8, 152};
    int tile_y [3] = '{0, 8, 112};
    int tile_id[3] = '{0, 5, 11};

    initial begin
        int  n_rise;
        int  rise_l;
        int  n_done;
        int  done_l;
        int  done_l2;
        int  width_err;
        int  spacing_err;
        logic prev_bd;

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        // ---------------- reset with start held high ----------------
        resetn      = 1'b0;
        bus_a.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_a($sformatf("rst%0d", i));
        end
        resetn = 1'b1;
        @(negedge clk);
        check("rst_release_fetch_busy", int'(bus_a.busy), 1);
        check("rst_release_addr", int'(bus_a.map_addr), 0);

        // Abort that render and return to a clean idle.
        resetn      = 1'b0;
        bus_a.start = 1'b0;
        @(negedge clk);
        check_idle_a("abort");
        resetn = 1'b1;
        @(negedge clk);

        // ---------------- full render, default grid ----------------
        n_rise = 0; rise_l = 0; n_done = 0; done_l = -1;
        width_err = 0; spacing_err = 0; prev_bd = 1'b0;
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        for (int label = 1; label <= 21905; label++) begin
            @(negedge clk);
            if (bus_a.begin_draw && !prev_bd) begin
                if (label != 3 + 73 * n_rise) spacing_err++;
                rise_l = label;
                n_rise++;
            end
            if (!bus_a.begin_draw && prev_bd) begin
                if (label - rise_l != 2) width_err++;
            end
            if (bus_a.done) begin
                n_done++;
                done_l = label;
            end
            for (int t = 0; t < 3; t++) begin
                if (label == 1 + 73 * tile_k[t])
                    check($sformatf("full_addr_t%0d", tile_k[t]),
                          int'(bus_a.map_addr), tile_k[t]);
                if (label == 3 + 73 * tile_k[t]) begin
                    check($sformatf("full_x_t%0d", tile_k[t]), int'(bus_a.x_out), tile_x[t]);
                    check($sformatf("full_y_t%0d", tile_k[t]), int'(bus_a.y_out), tile_y[t]);
                    check($sformatf("full_id_t%0d", tile_k[t]),
                          int'(bus_a.sprite_id_out), tile_id[t]);
                end
            end
            if (label == 21902) check("full_busy_after_done", int'(bus_a.busy), 0);
            prev_bd = bus_a.begin_draw;
        end
        check("full_pulses", n_rise, 300);
        check("full_width_errs", width_err, 0);
        check("full_spacing_errs", spacing_err, 0);
        check("full_done_count", n_done, 1);
        check("full_done_cycle", done_l, 21901);

        // ---------------- small grid, with ignored start ----------------
        n_rise = 0; n_done = 0; done_l = -1; prev_bd = 1'b0;
        bus_b.start = 1'b1;
        @(posedge clk);
        #1 bus_b.start = 1'b0;
        for (int label = 1; label <= 400; label++) begin
            @(negedge clk);
            if (bus_b.begin_draw && !prev_bd) n_rise++;
            if (bus_b.done) begin
                n_done++;
                done_l = label;
            end
            for (int k = 0; k < 4; k++)
                if (label == 1 + 73 * k)
                    check($sformatf("small_addr_t%0d", k), int'(bus_b.map_addr), k);
            if (label == 294) check("small_busy_after_done", int'(bus_b.busy), 0);
            prev_bd     = bus_b.begin_draw;
            bus_b.start = (label == 99);
        end
        check("small_pulses", n_rise, 4);
        check("small_done_count", n_done, 1);
        check("small_done_cycle", done_l, 293);

        // ---------------- back-to-back, start held high ----------------
        n_done = 0; done_l = -1; done_l2 = -1;
        bus_b.start = 1'b1;
        @(posedge clk);
        #1;
        for (int label = 1; label <= 600; label++) begin
            @(negedge clk);
            if (bus_b.done) begin
                n_done++;
                if (done_l < 0) done_l = label;
                else            done_l2 = label;
            end
            if (label == 294) check("b2b_idle_busy", int'(bus_b.busy), 0);
            if (label == 295) begin
                check("b2b_refetch_busy", int'(bus_b.busy), 1);
                check("b2b_refetch_addr", int'(bus_b.map_addr), 0);
            end
        end
        bus_b.start = 1'b0;
        check("b2b_done_count", n_done, 2);
        check("b2b_done1_cycle", done_l, 293);
        check("b2b_done2_cycle", done_l2, 587);

        // ---------------- reset during tile 5 GO ----------------
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        for (int label = 1; label <= 3 + 73 * 5; label++) @(negedge clk);
        check("mid_go_high", int'(bus_a.begin_draw), 1);
        check("mid_x_tile5", int'(bus_a.x_out), 40);
        check("mid_id_tile5", int'(bus_a.sprite_id_out), 5);
        resetn = 1'b0;
        @(negedge clk);
        check_idle_a("mid_rst");
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid_idle_busy%0d", i), int'(bus_a.busy), 0);
        end
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        @(negedge clk);
        check("restart_busy", int'(bus_a.busy), 1);
        check("restart_addr", int'(bus_a.map_addr), 0);
        @(negedge clk);
        @(negedge clk);
        check("restart_go", int'(bus_a.begin_draw), 1);
        check("restart_x", int'(bus_a.x_out), 0);
        check("restart_id", int'(bus_a.sprite_id_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_render_seq.md
# board_render_seq

Initiator that drives `sprite_draw` through the go/load handshake to repaint the full 160x120 screen as a grid of 8x8 tiles. It walks a tile map stored in an external synchronous-read board RAM, one tile at a time. For each tile it presents the pixel anchor and sprite id, pulses `begin_draw`, then waits long enough for the drawer to finish its 64-pixel plot. It sits between the game logic, which owns the board RAM and asserts `start`, and the `sprite_draw` instance.

## Interface
- `COLS`, default 20: tiles per row.
- `ROWS`, default 15: tile rows.
- `GO_CYCLES`, default 2: cycles `begin_draw` is held high per tile; must be ≥1.
- `WAIT_CYCLES`, default 68: cycles waited after `begin_draw` falls; must be ≥66.
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: request a full-board render; sampled only in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the last tile's wait completes.
- `map_addr`, out, 9: board RAM address, equal to row*COLS+col.
- `map_data`, in, 4: board RAM read data, valid the cycle after `map_addr` is presented.
- `x_out`, out, 8: tile anchor x, equal to col*8.
- `y_out`, out, 7: tile anchor y, equal to row*8.
- `sprite_id_out`, out, 4: sprite id for the current tile.
- `begin_draw`, out, 1: go signal to `sprite_draw`.

## Operation
- State machine: IDLE → FETCH → LATCH → GO → WAIT → ADVANCE → (FETCH | DONE); DONE → IDLE.
- IDLE: `start`=1 clears `col`, `row` and `map_addr` to 0, then moves to FETCH. `start`=0 stays in IDLE.
- FETCH, 1 cycle: `map_addr` is stable; RAM read is in flight.
- LATCH, 1 cycle: `map_data` is registered into `sprite_id_out`. `x_out` and `y_out` are registered as {col,3'b000} and {row,3'b000}.
- GO: `begin_draw`=1 for exactly `GO_CYCLES` cycles, counted by a down-counter.
- WAIT: `begin_draw`=0 for exactly `WAIT_CYCLES` cycles.
  - 66 is the minimum: 1 cycle for the drawer's load-wait state to see go low, 64 draw cycles, and 1 cycle to return to its load state.
  - The default of 68 adds 2 cycles of margin.
- ADVANCE, 1 cycle:
  - If col==COLS-1 and row==ROWS-1, go to DONE.
  - Else if col==COLS-1, set col=0 and row=row+1.
  - Else col=col+1.
  - Increment `map_addr` on every non-final ADVANCE; go to FETCH.
- DONE, 1 cycle: `done`=1, then go to IDLE.
- `x_out`, `y_out` and `sprite_id_out` only change in LATCH. They stay stable from LATCH through the end of WAIT, which covers the drawer's last load cycle (the cycle after go falls).
- `start` while `busy`=1 is ignored. No queuing: a `start` held through DONE is taken on the first IDLE cycle.
- Arithmetic: `map_addr` is 9 bits and unsigned; COLS*ROWS must be ≤512. Anchor multiplication by 8 is a shift only; no overflow is possible for defaults (max x 152, max y 112).

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `begin_draw`=0; `map_addr`=0, `x_out`=0, `y_out`=0, `sprite_id_out`=0.
- Reset mid-operation:
  - On the first edge with `resetn`=0, all outputs take their reset values; `begin_draw` drops that edge.
  - No partial tile is resumed after reset release.
- Per-tile period: T = 3 + GO_CYCLES + WAIT_CYCLES, which is 73 for defaults.
- Take the start-sampling edge as cycle 0. Tile k then runs:
  - FETCH at cycle 1+T·k.
  - `begin_draw` high in cycles 3+T·k through 2+GO_CYCLES+T·k.
- `done` is high in cycle 1+T·COLS·ROWS, which is cycle 21901 for defaults. `busy` falls the following cycle.
- `begin_draw` never rises while the drawer can still be in its draw state.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles with `start`=1 → every output reads 0 and `busy` stays 0. Release reset with `start`=1 → FETCH is entered on the next edge.
- Full render, defaults, with the RAM model map[a]=a mod 16:
  - Tile 0 latches x=0, y=0, id=0.
  - Tile 21 latches x=8, y=8, id=5.
  - Tile 299 latches x=152, y=112, id=11.
  - 300 `begin_draw` pulses, each 2 cycles wide, rising edges 73 cycles apart.
  - `done` in cycle 21901.
- Small grid, COLS=2, ROWS=2: `map_addr` sequence is 0,1,2,3; `done` in cycle 293; `start` pulse at cycle 100 is ignored, giving exactly 4 pulses.
- Reset mid-render: assert `resetn`=0 during tile 5 GO → `begin_draw` drops on the next edge and the block sits in IDLE. A new `start` restarts at `map_addr`=0.
- Integration with `sprite_draw`:
  - Full render produces exactly 64 `plot` cycles per tile, 19200 in total.
  - The plotted x/y span each tile's 8x8 block.
  - `begin_draw` is never seen high while the drawer is in its draw state.
- Back-to-back: `start` held high continuously → the second render's FETCH occurs 1 cycle after the DONE→IDLE transition, and `done` pulses once per render.
